// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (instruction/data) arbiter onto a single fixed-latency
//            memory; round-robin on ties, or fixed data priority when
//            MEM_ARB_DPRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_valid,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_last_cnt = 4'(LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_owner_d, w_owner_d_nxt;
  logic        r_wr, w_wr_nxt;
  logic [15:0] w_addr_nxt, w_wdata_nxt;
  logic [15:0] w_i_data_nxt, w_d_rdata_nxt;
  logic        w_pick_d;

`ifdef MEM_ARB_DPRIO_EN
  // Data side wins whenever it asks; no history needed.
  assign w_pick_d = d_req;
`else
  logic r_last_d;
  // On a tie, serve whichever side was not served last.
  assign w_pick_d = d_req && (!i_req || !r_last_d);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_owner_d_nxt = r_owner_d;
    w_wr_nxt      = r_wr;
    w_addr_nxt    = mem_addr;
    w_wdata_nxt   = mem_wdata;
    w_i_data_nxt  = i_data;
    w_d_rdata_nxt = d_rdata;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = '0;
          w_owner_d_nxt = w_pick_d;
          w_wr_nxt      = w_pick_d ? d_wr : 1'b0;
          w_addr_nxt    = w_pick_d ? d_addr : i_addr;
          w_wdata_nxt   = w_pick_d ? d_wdata : 16'h0000;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == c_last_cnt) begin
          w_state_nxt = S_DONE;
          if (!r_owner_d)
            w_i_data_nxt = mem_rdata;
          else if (!r_wr)
            w_d_rdata_nxt = mem_rdata;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every output is registered from the next-state view so it lines up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      i_grant   <= 1'b0;
      i_valid   <= 1'b0;
      i_data    <= '0;
      d_grant   <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_owner_d <= w_owner_d_nxt;
      r_wr      <= w_wr_nxt;
      i_grant   <= (w_state_nxt != S_IDLE) && !w_owner_d_nxt;
      d_grant   <= (w_state_nxt != S_IDLE) && w_owner_d_nxt;
      i_valid   <= (w_state_nxt == S_DONE) && !w_owner_d_nxt;
      d_valid   <= (w_state_nxt == S_DONE) && w_owner_d_nxt;
      i_data    <= w_i_data_nxt;
      d_rdata   <= w_d_rdata_nxt;
      mem_en    <= (w_state_nxt == S_BUSY);
      mem_wr    <= (w_state_nxt == S_BUSY) && w_wr_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      busy      <= (w_state_nxt != S_IDLE);
    end
  end

`ifndef MEM_ARB_DPRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_d <= 1'b0;
    else if (r_state == S_IDLE && (i_req || d_req))
      r_last_d <= w_pick_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter against a transaction-level
//            reference model (LATENCY=4 main instance, LATENCY=1 second instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        i_grant, i_valid, d_grant, d_valid, mem_en, mem_wr, busy;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;

  logic        rst_1 = 1'b1, i_req_1 = 1'b0;
  logic        i_grant_1, i_valid_1, d_grant_1, d_valid_1, mem_en_1, mem_wr_1, busy_1;
  logic [15:0] i_data_1, d_rdata_1, mem_addr_1, mem_wdata_1;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst_1),
    .i_req(i_req_1), .i_addr(16'h0123), .i_grant(i_grant_1), .i_valid(i_valid_1), .i_data(i_data_1),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_grant(d_grant_1), .d_valid(d_valid_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_wr(mem_wr_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(16'h5A5A), .busy(busy_1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who was served last and what each side last read.
  logic        m_last_d = 1'b0;
  logic [15:0] m_idata  = '0;
  logic [15:0] m_drdata = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},    {15'd0, busy},    16'd0);
    chk({tag, ".grant"},   {14'd0, i_grant, d_grant}, 16'd0);
    chk({tag, ".valid"},   {14'd0, i_valid, d_valid}, 16'd0);
    chk({tag, ".mem_en"},  {15'd0, mem_en},  16'd0);
    chk({tag, ".i_data"},  i_data,  m_idata);
    chk({tag, ".d_rdata"}, d_rdata, m_drdata);
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input string tag, input logic ir, input logic dr, input logic dw,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
    logic        win_d;
    logic [15:0] cap;
    i_req = ir; d_req = dr; d_wr = dw; i_addr = ia; d_addr = da; d_wdata = wd;
    @(posedge clk);
    if (!ir && !dr) begin
      @(negedge clk);
      check_idle({tag, ".noreq"});
      return;
    end
`ifdef MEM_ARB_DPRIO_EN
    win_d = dr;
`else
    win_d = dr && (!ir || !m_last_d);
`endif
    m_last_d = win_d;
    cap = '0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk({tag, ".busy"},     {15'd0, busy},    16'd1);
      chk({tag, ".mem_en"},   {15'd0, mem_en},  16'd1);
      chk({tag, ".mem_wr"},   {15'd0, mem_wr},  {15'd0, win_d & dw});
      chk({tag, ".mem_addr"}, mem_addr, win_d ? da : ia);
      if (win_d) chk({tag, ".mem_wdata"}, mem_wdata, wd);
      chk({tag, ".grant"},    {14'd0, i_grant, d_grant}, win_d ? 16'd1 : 16'd2);
      chk({tag, ".valid"},    {14'd0, i_valid, d_valid}, 16'd0);
      // The loser's request wiggles during the transaction and must be ignored.
      if (win_d) i_req = 1'($urandom_range(0, 1)); else d_req = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      cap = mem_rdata;
      @(posedge clk);
    end
    @(negedge clk);
    if (!win_d) m_idata = cap;
    else if (!dw) m_drdata = cap;
    chk({tag, ".done.busy"},   {15'd0, busy},   16'd1);
    chk({tag, ".done.mem_en"}, {15'd0, mem_en}, 16'd0);
    chk({tag, ".done.grant"},  {14'd0, i_grant, d_grant}, win_d ? 16'd1 : 16'd2);
    chk({tag, ".done.valid"},  {14'd0, i_valid, d_valid}, win_d ? 16'd1 : 16'd2);
    chk({tag, ".done.i_data"}, i_data,  m_idata);
    chk({tag, ".done.d_rdata"}, d_rdata, m_drdata);
    i_req = 1'($urandom_range(0, 1));
    d_req = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    check_idle({tag, ".after"});
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check_idle("reset");
    chk("reset.mem_addr",  mem_addr,  16'd0);
    chk("reset.mem_wdata", mem_wdata, 16'd0);
    chk("reset.mem_wr",    {15'd0, mem_wr}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn("i_read",  1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    run_txn("d_read",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000);
    run_txn("d_write", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'h1234);
    for (int t = 0; t < 4; t++)
      run_txn("tie", 1'b1, 1'b1, 1'b0, 16'h0400 + 16'(t), 16'h0800 + 16'(t), 16'h0000);

    // Abort a read in its second BUSY cycle, then let the held request restart.
    i_req = 1'b1; d_req = 1'b0; i_addr = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    chk("abort.busy1", {15'd0, mem_en}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_last_d = 1'b0; m_idata = '0; m_drdata = '0;
    check_idle("abort.rst");
    chk("abort.mem_addr", mem_addr, 16'd0);
    @(posedge clk);
    @(negedge clk);
    check_idle("abort.hold");
    rst = 1'b0;
    run_txn("restart", 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000);
    run_txn("tie_after_rst", 1'b1, 1'b1, 1'b0, 16'h0050, 16'h0060, 16'h0000);

    for (int t = 0; t < 40; t++)
      run_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));

    // LATENCY=1 instance: a held fetch completes every third cycle.
    i_req_1 = 1'b1;
    @(negedge clk);
    rst_1 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk("l1.mem_en",  {15'd0, mem_en_1},  {15'd0, n % 3 == 1});
      chk("l1.i_valid", {15'd0, i_valid_1}, {15'd0, n % 3 == 2});
      chk("l1.d_grant", {15'd0, d_grant_1}, 16'd0);
      if (n % 3 == 2) chk("l1.i_data", i_data_1, 16'h5A5A);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: LATENCY, 4, memory access cycles per transaction (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: i_req input 1, instruction-side request (level); i_addr input 16, fetch address.
REQ-005 SHALL have ports: i_grant output 1, I-side owns memory; i_valid output 1, fetch data valid pulse; i_data output 16, fetch data.
REQ-006 SHALL have ports: d_req input 1, data-side request (level); d_wr input 1, 1=write; d_addr input 16; d_wdata input 16.
REQ-007 SHALL have ports: d_grant output 1; d_valid output 1, completion pulse (read or write); d_rdata output 16.
REQ-008 SHALL have ports: mem_en output 1; mem_wr output 1; mem_addr output 16; mem_wdata output 16; mem_rdata input 16.
REQ-009 SHALL have port: busy output 1, high when state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-011 IDLE: on an edge with any req high, SHALL select an owner, latch addr/wr/wdata of that owner, enter BUSY, clear cnt to 0.
REQ-012 Only one req high: that side SHALL win regardless of arbitration mode.
REQ-013 BUSY: mem_en SHALL be 1 every cycle, mem_addr/mem_wr/mem_wdata held at latched values; mem_wr=0 for I-side.
REQ-014 BUSY: cnt SHALL increment each edge; at edge with cnt==LATENCY-1, SHALL capture mem_rdata (reads) and enter DONE.
REQ-015 DONE: owner's valid SHALL be 1 for exactly one cycle, mem_en=0, no request accepted; next state IDLE.
REQ-016 Owner's grant SHALL be 1 throughout BUSY and DONE, 0 otherwise; i_grant and d_grant never both 1.
REQ-017 Latency: req sampled at edge E0 -> valid high in cycle following edge E0+LATENCY; next acceptance earliest at edge E0+LATENCY+2.
REQ-018 i_data/d_rdata SHALL hold last captured value until next read completion for that side; d_rdata unchanged on writes.
REQ-019 Requester SHALL hold req, addr, wr, wdata stable until its valid; req changes during BUSY/DONE SHALL be ignored.
REQ-020 Requester dropping req before grant SHALL simply not be served; no state is recorded.
REQ-021 Last-served bit SHALL record owner on each IDLE->BUSY transition.

Reset
REQ-022 rst SHALL immediately force IDLE, cnt=0, all outputs 0 (including i_data, d_rdata, mem_*), last-served=I.
REQ-023 Reset mid-transaction SHALL abort without any valid pulse; after release, pending reqs are re-arbitrated from IDLE.

Configuration
REQ-024 Macro MEM_ARB_DPRIO_EN defined: simultaneous requests SHALL always grant D-side (fixed data priority; last-served bit unused).
REQ-025 Macro MEM_ARB_DPRIO_EN undefined: simultaneous requests SHALL grant the side not last served (round-robin; first tie after reset goes to D).

Verification
REQ-026 LATENCY=4, i_req=1 at 0x0010, mem_rdata=0xA5A5 -> mem_en 4 cycles, i_valid one cycle after 4th BUSY cycle, i_data=0xA5A5, d_grant stays 0.
REQ-027 d_req=1,d_wr=1,d_addr=0x0200,d_wdata=0x1234 -> mem_wr=1,mem_addr=0x0200,mem_wdata=0x1234 for 4 cycles, d_valid pulse, d_rdata unchanged.
REQ-028 i_req and d_req held high continuously, macro undefined -> owners D,I,D,I...; macro defined -> D every transaction, i_valid never pulses.
REQ-029 rst asserted in 2nd BUSY cycle of a read -> all outputs 0 that cycle, no valid pulse; after release with req held, transaction restarts, full LATENCY.
REQ-030 LATENCY=1, i_req held -> one BUSY cycle, DONE, IDLE, repeat; i_valid period 3 cycles, mem_en duty 1/3.
